// File: rtl/reg_file_if.sv
// Write/read bus between the control unit and reg_file.
// Master drives the write port and read addresses; slave returns data and flags.
interface reg_file_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [1:0]       op;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic             flag_c;
  logic             flag_z;

  modport master (
    output we, op, waddr, wdata,
    output raddr_a, raddr_b,
    input  rdata_a, rdata_b,
    input  flag_c, flag_z
  );

  modport slave (
    input  we, op, waddr, wdata,
    input  raddr_a, raddr_b,
    output rdata_a, rdata_b,
    output flag_c, flag_z
  );
endinterface

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: 1 modify-write port, 2 async read ports, C/Z flags.
// Optional write-through forwarding on reads: define REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int          WIDTH     = 4,
  parameter int          DEPTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             c_q, c_d;
  logic             z_q, z_d;

  logic             wr_ok;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  op_e              op;

  assign op    = op_e'(bus.op);
  assign wr_ok = bus.we && ({1'b0, bus.waddr} < DEPTH_W);

  always_comb begin
    cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.waddr == AW'(i)) cur = mem_q[i];
    end
  end

  // Shared by the commit path and the forwarding mux.
  always_comb begin
    res   = cur;
    carry = 1'b0;
    unique case (op)
      OP_LOAD: res = bus.wdata;
      OP_INC: begin
        res   = cur + WIDTH'(1);
        carry = &cur;
      end
      OP_DEC: begin
        res   = cur - WIDTH'(1);
        carry = ~|cur;
      end
      OP_CLR:  res = '0;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    c_d   = c_q;
    z_d   = z_q;
    if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.waddr == AW'(i)) mem_d[i] = res;
      end
      c_d = carry;
      z_d = (res == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_W;
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      c_q   <= c_d;
      z_q   <= z_d;
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.raddr_a == AW'(i)) rd_a = mem_q[i];
      if (bus.raddr_b == AW'(i)) rd_b = mem_q[i];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && bus.raddr_a == bus.waddr) rd_a = res;
    if (wr_ok && bus.raddr_b == bus.waddr) rd_b = res;
`endif
  end

  assign bus.rdata_a = rd_a;
  assign bus.rdata_b = rd_b;
  assign bus.flag_c  = c_q;
  assign bus.flag_z  = z_q;
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
Parametrised multi-register storage block, the successor to the single-register `Reg`. It holds DEPTH words of WIDTH bits, with one write port and two independent read ports. The write port supports in-place modify operations: load, increment, decrement and clear. Registered carry and zero flags are updated on every write. It sits between the CPU control unit (write side) and the ALU operand muxes (read side).

Parameters:
- WIDTH, 4, data word width in bits (≥2)
- DEPTH, 4, number of registers (≥2, need not be a power of two)
- RESET_VAL, 0, value loaded into every register on reset (truncated to WIDTH)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable; operation performed at the rising edge when high
- op  in  2  write operation: 00 LOAD, 01 INC, 10 DEC, 11 CLR
- waddr  in  $clog2(DEPTH)  register index for the write
- wdata  in  WIDTH  write data (used by LOAD only)
- raddr_a  in  $clog2(DEPTH)  read port A index
- rdata_a  out  WIDTH  read port A data
- raddr_b  in  $clog2(DEPTH)  read port B index
- rdata_b  out  WIDTH  read port B data
- flag_c  out  1  carry/borrow of the last executed write
- flag_z  out  1  result of the last executed write was zero

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - every register = RESET_VAL; flag_c=0; flag_z=0.
  - Read ports then show RESET_VAL combinationally.
  - Reset asserted mid-sequence overrides any write in progress; the write is lost.
- Write (we=1 at the rising edge, waddr < DEPTH), with R = mem[waddr]:
  - LOAD: R ← wdata; flag_c ← 0.
  - INC: R ← R+1 modulo 2^WIDTH; flag_c ← 1 only if old R was all-ones (wrap to 0).
  - DEC: R ← R−1 modulo 2^WIDTH; flag_c ← 1 only if old R was 0 (borrow, wrap to all-ones).
  - CLR: R ← 0; flag_c ← 0.
  - flag_z ← (new R == 0) for every op.
  - Latency: new value and flags visible one edge after the write.
  - Back-to-back writes: each uses the value committed by the previous edge, so INC,INC on the same register adds 2.
- we=0: no register or flag changes; flags hold the last result indefinitely.
- waddr ≥ DEPTH (non-power-of-two DEPTH): the write is ignored and flags hold.
- Read:
  - rdata_a/rdata_b are purely combinational from storage, with zero-cycle latency.
  - Both ports may address the same register simultaneously.
  - raddr ≥ DEPTH returns 0.
  - Reading the register being written in the same cycle returns the OLD value, unless the bypass feature below is compiled in.
- Only one write per cycle; there are no write-write conflicts.
- No X propagation: all storage is initialised by reset; outputs are defined whenever rst has been asserted once.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN
- Defined: write-through forwarding. When we=1, waddr < DEPTH and raddr_x == waddr, rdata_x shows the result the pending op will commit: wdata for LOAD, R±1 for INC/DEC, 0 for CLR. The mux is combinational, with the same op decode as the write path; flags are not forwarded.
- Undefined: reads always reflect committed storage (old value during the write cycle).

Test Plan:
1. Reset: rst=1 at t=0, with RESET_VAL=0 and any raddr → rdata_a=rdata_b=0, flag_c=0, flag_z=0, with no clock edge required.
2. Load/readback: LOAD 4'b1010→r1, then LOAD 4'b1111→r2, then raddr_a=1, raddr_b=2 → rdata_a=4'hA, rdata_b=4'hF; flag_z=0, flag_c=0.
3. Increment wrap: r2=4'hF, then INC r2 → r2=0, flag_c=1, flag_z=1; next INC → r2=1, flag_c=0, flag_z=0.
4. Decrement borrow: CLR r3 (flag_z=1), then DEC r3 → r3=4'hF, flag_c=1, flag_z=0; hold we=0 for 3 cycles → flags unchanged.
5. Same-cycle read of the write target: LOAD 4'h5→r0 with raddr_a=0.
   - Without REG_FILE_BYPASS_EN, rdata_a shows the old value until the edge, then 5.
   - With REG_FILE_BYPASS_EN, rdata_a=5 within the same cycle.
6. Mid-operation reset: r1=4'hA, then assert rst asynchronously between edges while we=1, op=INC, waddr=1 → r1=0 immediately; after deassert with we=0, r1 stays 0 and flags stay 0. Also check that with DEPTH=3, a write to waddr=3 is ignored.
